aes_iter_engine: RTL and testbench

Iterative, parametrised AES engine: one cipher round per clock, key length selectable at elaboration (AES-128/192/256), and encrypt or decrypt selected per operation. It replaces the fixed AES-128 demo top with a reusable datapath core that has an explicit start/busy/done handshake and a defined reset. It sits between any block-level controller (display/test top, future mode wrappers such as CBC/CTR) and the existing round logic.

---
 rtl/aes_pkg.sv | 109 ++++++++++
 rtl/aes_round.sv | 40 ++++
 rtl/aes_iter_engine.sv | 97 +++++++++
 tb/tb_aes_iter_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES field arithmetic, S-boxes, column mixing and key schedule helpers
package aes_pkg;

    localparam int NK_128 = 4;
    localparam int NK_192 = 6;
    localparam int NK_256 = 8;

    // Byte 0 (FIPS-197 order) is the most significant byte; byte n sits at row n%4, column n/4.
    typedef logic [0:15][7:0] aes_state_t;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = xtime(p);
        end
        return r;
    endfunction

    // x^254 == x^-1 in GF(2^8); zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 1; j < 15; j++) begin
            if (j < n) r = xtime(r);
        end
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Key is MSB-aligned in 256 bits; returns round key idx of the NK-word schedule.
    function automatic logic [127:0] expand_round_key(input logic [255:0] key, input int nk,
                                                      input int idx);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * (i % 8) -: 32];
            end else begin
                t = w[i - 1];
                if (i % nk == 0)
                    t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h000000};
                else if (nk > 6 && i % nk == 4)
                    t = sub_word(t);
                w[i] = w[i - nk] ^ t;
            end
        end
        return {w[4 * idx], w[4 * idx + 1], w[4 * idx + 2], w[4 * idx + 3]};
    endfunction

endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - one combinational AES round, encrypt or decrypt
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         decrypt,
    input  logic         final_round,
    output logic [127:0] next_state
);

    aes_state_t s_in, sub, shf, mix, inv_shf, inv_sub, ark;

    always_comb begin
        s_in    = state;
        sub     = '0;
        shf     = '0;
        mix     = '0;
        inv_shf = '0;
        inv_sub = '0;
        for (int n = 0; n < 16; n++) sub[n] = sbox(s_in[n]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf[4 * c + r]     = sub[4 * ((c + r) % 4) + r];
                inv_shf[4 * c + r] = s_in[4 * ((c - r + 4) % 4) + r];
            end
        end
        for (int n = 0; n < 16; n++) inv_sub[n] = inv_sbox(inv_shf[n]);
        ark = inv_sub ^ round_key;
        for (int c = 0; c < 4; c++) begin
            mix[4 * c +: 4] = decrypt ? inv_mix_column(ark[4 * c +: 4])
                                      : mix_column(shf[4 * c +: 4]);
        end
        if (decrypt)
            next_state = final_round ? ark : mix;
        else
            next_state = (final_round ? shf : mix) ^ round_key;
    end

endmodule

// File: rtl/aes_iter_engine.sv
// rtl/aes_iter_engine.sv - iterative AES-128/192/256 core, one round per clock, start/busy/done
module aes_iter_engine
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = NK + 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              decrypt,
    input  logic [32*NK-1:0]  key,
    input  logic [127:0]      data_in,
    output logic              busy,
    output logic              done,
    output logic [127:0]      data_out
);

    if (!(NK == NK_128 || NK == NK_192 || NK == NK_256) || NR != nr_of(NK)) begin : g_bad_param
        $error("aes_iter_engine: NK must be 4, 6 or 8 and NR must equal NK+6");
    end

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       fsm;
    logic [127:0]     state_q;
    logic [32*NK-1:0] key_q;
    logic             dec_q;
    logic [3:0]       round_q;

    logic [255:0] key_wide;
    logic         first_round, last_round;
    int           wk_idx, rk_idx;
    logic [127:0] whiten_key, round_key, round_in, round_out;

    // state_q holds the raw input block after start; the initial AddRoundKey is folded
    // into round 1 so every round key comes from key_q, never from the key port.
    always_comb begin
        key_wide    = 256'(key_q) << (256 - 32 * NK);
        first_round = (round_q == 4'd1);
        last_round  = (round_q == 4'(NR));
        wk_idx      = dec_q ? NR : 0;
        rk_idx      = dec_q ? NR - int'(round_q) : int'(round_q);
        whiten_key  = expand_round_key(key_wide, NK, wk_idx);
        round_key   = expand_round_key(key_wide, NK, rk_idx);
        round_in    = first_round ? (state_q ^ whiten_key) : state_q;
    end

    aes_round u_round (
        .state       (round_in),
        .round_key   (round_key),
        .decrypt     (dec_q),
        .final_round (last_round),
        .next_state  (round_out)
    );

    assign busy = (fsm == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= IDLE;
            state_q  <= '0;
            key_q    <= '0;
            dec_q    <= 1'b0;
            round_q  <= 4'd0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        key_q   <= key;
                        dec_q   <= decrypt;
                        state_q <= data_in;
                        round_q <= 4'd1;
                        fsm     <= RUN;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    if (last_round) begin
                        data_out <= round_out;
                        done     <= 1'b1;
                        round_q  <= 4'd0;
                        fsm      <= IDLE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_engine.sv
// tb/tb_aes_iter_engine.sv - self-checking bench for aes_iter_engine at NK=4/6/8
module tb_aes_iter_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start [3];
    logic         decrypt;
    logic [255:0] key_bus;
    logic [127:0] data_in;
    logic         busy [3];
    logic         done [3];
    logic [127:0] dout [3];

    always #5 clk = ~clk;

    aes_iter_engine #(.NK(4)) dut4 (.clk(clk), .rst(rst), .start(start[0]), .decrypt(decrypt),
        .key(key_bus[255:128]), .data_in(data_in), .busy(busy[0]), .done(done[0]), .data_out(dout[0]));
    aes_iter_engine #(.NK(6)) dut6 (.clk(clk), .rst(rst), .start(start[1]), .decrypt(decrypt),
        .key(key_bus[255:64]), .data_in(data_in), .busy(busy[1]), .done(done[1]), .data_out(dout[1]));
    aes_iter_engine #(.NK(8)) dut8 (.clk(clk), .rst(rst), .start(start[2]), .decrypt(decrypt),
        .key(key_bus), .data_in(data_in), .busy(busy[2]), .done(done[2]), .data_out(dout[2]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: table S-box built from the generator-3 walk, FIPS-197 cipher on byte arrays.
    bit [7:0] sb [256];
    bit [7:0] isb [256];

    function automatic bit [7:0] gm(bit [7:0] a, bit [7:0] b);
        bit [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= a;
            a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic void build_sbox();
        bit [7:0] p = 8'h01, q = 8'h01, x;
        for (int n = 0; n < 255; n++) begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q ^= q << 1;
            q ^= q << 2;
            q ^= q << 4;
            if (q[7]) q ^= 8'h09;
            x = q ^ ((q << 1) | (q >> 7)) ^ ((q << 2) | (q >> 6))
                  ^ ((q << 3) | (q >> 5)) ^ ((q << 4) | (q >> 4));
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endfunction

    function automatic logic [127:0] ref_aes(int nk, bit dec, logic [255:0] kb, logic [127:0] din);
        int nr = nk + 6;
        bit [7:0] w [60][4];
        bit [7:0] tmp [4];
        bit [7:0] s [16];
        bit [7:0] t [16];
        bit [7:0] a [4];
        bit [7:0] rc = 8'h01;
        int rk;
        logic [127:0] res;
        for (int i = 0; i < nk; i++)
            for (int j = 0; j < 4; j++) w[i][j] = kb[255 - 32 * i - 8 * j -: 8];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i - 1];
            if (i % nk == 0) begin
                tmp = '{sb[w[i-1][1]] ^ rc, sb[w[i-1][2]], sb[w[i-1][3]], sb[w[i-1][0]]};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) tmp[j] = sb[tmp[j]];
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i - nk][j] ^ tmp[j];
        end
        for (int n = 0; n < 16; n++) s[n] = din[127 - 8 * n -: 8];
        rk = dec ? nr : 0;
        for (int n = 0; n < 16; n++) s[n] ^= w[4 * rk + n / 4][n % 4];
        for (int r = 1; r <= nr; r++) begin
            if (!dec) begin
                for (int n = 0; n < 16; n++) s[n] = sb[s[n]];
                for (int col = 0; col < 4; col++)
                    for (int row = 0; row < 4; row++) t[row + 4 * col] = s[row + 4 * ((col + row) % 4)];
                s = t;
                if (r < nr) begin
                    for (int col = 0; col < 4; col++) begin
                        for (int i = 0; i < 4; i++) a[i] = s[4 * col + i];
                        s[4*col]   = gm(a[0], 2) ^ gm(a[1], 3) ^ a[2] ^ a[3];
                        s[4*col+1] = a[0] ^ gm(a[1], 2) ^ gm(a[2], 3) ^ a[3];
                        s[4*col+2] = a[0] ^ a[1] ^ gm(a[2], 2) ^ gm(a[3], 3);
                        s[4*col+3] = gm(a[0], 3) ^ a[1] ^ a[2] ^ gm(a[3], 2);
                    end
                end
                for (int n = 0; n < 16; n++) s[n] ^= w[4 * r + n / 4][n % 4];
            end else begin
                for (int col = 0; col < 4; col++)
                    for (int row = 0; row < 4; row++) t[row + 4 * col] = s[row + 4 * ((col - row + 4) % 4)];
                for (int n = 0; n < 16; n++) s[n] = isb[t[n]] ^ w[4 * (nr - r) + n / 4][n % 4];
                if (r < nr) begin
                    for (int col = 0; col < 4; col++) begin
                        for (int i = 0; i < 4; i++) a[i] = s[4 * col + i];
                        s[4*col]   = gm(a[0], 14) ^ gm(a[1], 11) ^ gm(a[2], 13) ^ gm(a[3], 9);
                        s[4*col+1] = gm(a[0], 9) ^ gm(a[1], 14) ^ gm(a[2], 11) ^ gm(a[3], 13);
                        s[4*col+2] = gm(a[0], 13) ^ gm(a[1], 9) ^ gm(a[2], 14) ^ gm(a[3], 11);
                        s[4*col+3] = gm(a[0], 11) ^ gm(a[1], 13) ^ gm(a[2], 9) ^ gm(a[3], 14);
                    end
                end
            end
        end
        for (int n = 0; n < 16; n++) res[127 - 8 * n -: 8] = s[n];
        return res;
    endfunction

    // Launch one block on instance k and wait (bounded) for its done pulse.
    task automatic run_op(input int k, input bit dec, input logic [255:0] kb, input logic [127:0] d,
                          output logic [127:0] res, output int lat);
        @(negedge clk);
        decrypt  = dec;
        key_bus  = kb;
        data_in  = d;
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        check("busy_after_start", 128'(busy[k]), 128'(1));
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done[k]) begin
                lat = c;
                break;
            end
        end
        res = dout[k];
        check("busy_after_done", 128'(busy[k]), 128'(0));
    endtask

    typedef struct {
        int           k;
        bit           dec;
        logic [255:0] key;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t         vt [6];
        logic [127:0] res;
        logic [127:0] exp;
        logic [255:0] kr;
        int           lat, k, ndone, first_done;
        bit           dec, hold_ok;

        build_sbox();
        vt[0] = '{0, 1'b0, K128, PT, C128};
        vt[1] = '{0, 1'b1, K128, C128, PT};
        vt[2] = '{1, 1'b0, K192, PT, C192};
        vt[3] = '{1, 1'b1, K192, C192, PT};
        vt[4] = '{2, 1'b0, K256, PT, C256};
        vt[5] = '{2, 1'b1, K256, C256, PT};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        decrypt = 1'b0;
        key_bus = '0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_busy", 128'(busy[i]), 128'(0));
            check("reset_done", 128'(done[i]), 128'(0));
            check("reset_data_out", dout[i], 128'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_op(vt[v].k, vt[v].dec, vt[v].key, vt[v].din, res, lat);
            check($sformatf("vec%0d_result", v), res, vt[v].exp);
            check($sformatf("vec%0d_latency", v), 128'(lat), 128'(10 + 2 * vt[v].k));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_width", v), 128'(done[vt[v].k]), 128'(0));
        end

        for (int n = 0; n < 12; n++) begin
            k   = int'($urandom_range(0, 2));
            dec = 1'($urandom_range(0, 1));
            kr  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            exp = {$urandom, $urandom, $urandom, $urandom};
            run_op(k, dec, kr, exp, res, lat);
            check($sformatf("rand%0d_result", n), res, ref_aes(4 + 2 * k, dec, kr, exp));
            check($sformatf("rand%0d_latency", n), 128'(lat), 128'(10 + 2 * k));
        end

        // start pulses and key/data churn while busy must not disturb the running block
        @(negedge clk);
        decrypt = 1'b0; key_bus = K128; data_in = PT; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        ndone = 0;
        first_done = -1;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk);
            #1;
            if (done[0]) begin
                ndone++;
                if (first_done < 0) first_done = c;
                if (c == 10) res = dout[0];
            end
            start[0] = (c == 3 || c == 6);
            key_bus  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            data_in  = {$urandom, $urandom, $urandom, $urandom};
            if (c >= 8) start[0] = 1'b0;
        end
        check("busy_ignore_result", res, C128);
        check("busy_ignore_done_count", 128'(ndone), 128'(1));
        check("busy_ignore_latency", 128'(first_done), 128'(10));

        // start raised in the done cycle is accepted; data_out holds the first result meanwhile
        run_op(0, 1'b0, K128, PT, res, lat);
        check("b2b_first_result", res, C128);
        decrypt = 1'b1; key_bus = K128; data_in = C128; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        hold_ok = 1'b1;
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (done[0]) begin
                lat = c;
                break;
            end
            if (dout[0] !== C128) hold_ok = 1'b0;
        end
        check("b2b_hold", 128'(hold_ok), 128'(1));
        check("b2b_latency", 128'(lat), 128'(10));
        check("b2b_second_result", dout[0], PT);

        // asynchronous reset at round 5 aborts without a done pulse
        @(negedge clk);
        decrypt = 1'b0; key_bus = K256; data_in = PT; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 128'(busy[0]), 128'(0));
        check("abort_done", 128'(done[0]), 128'(0));
        check("abort_data_out", dout[0], 128'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done[0]) ndone++;
        end
        check("abort_no_done", 128'(ndone), 128'(0));
        run_op(0, 1'b0, K256, PT, res, lat);
        check("after_abort_result", res, ref_aes(4, 1'b0, K256, PT));
        check("after_abort_latency", 128'(lat), 128'(10));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
